// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/bubble controller: load-use hazards, multi-cycle EX occupancy, mem_wait freeze.
// Latency: controls are combinational; only state, cnt and stall_count are registered. mem_wait freezes everything.
module hazard_stall_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 12,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_regdest,
  input  logic             ex_writereg,
  input  logic             ex_is_load,
  input  logic             ex_mc_start,
  input  logic             ex_mc_div,
  input  logic             mem_wait,
  output logic             hold_if,
  output logic             hold_id,
  output logic             bubble_idex,
  output logic             hold_ex,
  output logic             bubble_exmem,
  output logic             mc_busy,
  output logic             mc_done,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {IDLE, MC_BUSY} state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 2);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 2);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       luh;

  assign luh = ex_is_load & ex_writereg & (ex_regdest != 5'd0) &
               ((id_uses_rs & (id_rs == ex_regdest)) |
                (id_uses_rt & (id_rt == ex_regdest)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      stall_count <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (hold_if && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    hold_if      = 1'b0;
    hold_id      = 1'b0;
    bubble_idex  = 1'b0;
    hold_ex      = 1'b0;
    bubble_exmem = 1'b0;
    mc_busy      = 1'b0;
    mc_done      = 1'b0;
    if (!reset) begin
      bubble_idex  = 1'b1;
      bubble_exmem = 1'b1;
    end else if (mem_wait) begin
      // Freeze: a pending start is re-presented once the freeze lifts
      hold_if = 1'b1;
      hold_id = 1'b1;
      hold_ex = 1'b1;
      mc_busy = (state == MC_BUSY);
    end else begin
      case (state)
        IDLE: begin
          if (ex_mc_start) begin
            cnt_nxt      = ex_mc_div ? DIV_CNT : MULT_CNT;
            state_nxt    = MC_BUSY;
            hold_if      = 1'b1;
            hold_id      = 1'b1;
            hold_ex      = 1'b1;
            bubble_exmem = 1'b1;
            mc_busy      = 1'b1;
          end else if (luh) begin
            hold_if     = 1'b1;
            hold_id     = 1'b1;
            bubble_idex = 1'b1;
          end
        end
        MC_BUSY: begin
          if (cnt != 4'd0) begin
            cnt_nxt      = cnt - 4'd1;
            hold_if      = 1'b1;
            hold_id      = 1'b1;
            hold_ex      = 1'b1;
            bubble_exmem = 1'b1;
            mc_busy      = 1'b1;
          end else begin
            state_nxt   = IDLE;
            mc_done     = 1'b1;
            hold_if     = luh;
            hold_id     = luh;
            bubble_idex = luh;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Vector-table bench for hazard_stall_ctrl; expectations queued at drive time, popped at the sampling edge.
module tb_hazard_stall_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_regdest = '0;
  logic       id_uses_rs = 0, id_uses_rt = 0, ex_writereg = 0, ex_is_load = 0;
  logic       ex_mc_start = 0, ex_mc_div = 0, mem_wait = 0;

  logic        hold_if, hold_id, bubble_idex, hold_ex, bubble_exmem, mc_busy, mc_done;
  logic [15:0] stall_count;
  logic        s_hold_if, s_hold_id, s_bubble_idex, s_hold_ex, s_bubble_exmem, s_mc_busy, s_mc_done;
  logic [3:0]  s_stall_count;

  always #5 clock = ~clock;

  hazard_stall_ctrl dut (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_regdest(ex_regdest),
    .ex_writereg(ex_writereg), .ex_is_load(ex_is_load), .ex_mc_start(ex_mc_start),
    .ex_mc_div(ex_mc_div), .mem_wait(mem_wait), .hold_if(hold_if), .hold_id(hold_id),
    .bubble_idex(bubble_idex), .hold_ex(hold_ex), .bubble_exmem(bubble_exmem),
    .mc_busy(mc_busy), .mc_done(mc_done), .stall_count(stall_count)
  );

  hazard_stall_ctrl #(.CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_regdest(ex_regdest),
    .ex_writereg(ex_writereg), .ex_is_load(ex_is_load), .ex_mc_start(ex_mc_start),
    .ex_mc_div(ex_mc_div), .mem_wait(mem_wait), .hold_if(s_hold_if), .hold_id(s_hold_id),
    .bubble_idex(s_bubble_idex), .hold_ex(s_hold_ex), .bubble_exmem(s_bubble_exmem),
    .mc_busy(s_mc_busy), .mc_done(s_mc_done), .stall_count(s_stall_count)
  );

  // Output bit order: hold_if hold_id bubble_idex hold_ex bubble_exmem mc_busy mc_done
  localparam bit [6:0] E_IDLE = 7'b0000000;
  localparam bit [6:0] E_RST  = 7'b0010100;
  localparam bit [6:0] E_LUH  = 7'b1110000;
  localparam bit [6:0] E_MCB  = 7'b1101110;
  localparam bit [6:0] E_DONE = 7'b0000001;
  localparam bit [6:0] E_FRZ  = 7'b1101000;
  localparam bit [6:0] ALL    = 7'h7F;
  localparam bit [6:0] NOBUSY = 7'h7D;

  typedef struct {
    string    name;
    bit       rst, mw, st, dv, ld, wr, urs, urt;
    bit [4:0] rd, rs, rt;
    bit [6:0] exp, care;
  } vec_t;

  typedef struct {
    string    name;
    bit [6:0] exp, care;
    int       sc16, sc4;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   sc16 = 0, sc4 = 0;

  function automatic vec_t mk(string n, bit rst, bit mw, bit st, bit dv, bit ld, bit wr,
                              bit [4:0] rd, bit urs, bit [4:0] rs, bit urt, bit [4:0] rt,
                              bit [6:0] e, bit [6:0] c);
    vec_t v;
    v.name = n; v.rst = rst; v.mw = mw; v.st = st; v.dv = dv; v.ld = ld; v.wr = wr;
    v.rd = rd; v.urs = urs; v.rs = rs; v.urt = urt; v.rt = rt; v.exp = e; v.care = c;
    return v;
  endfunction

  function automatic vec_t idle(string n, bit [6:0] e, bit [6:0] c);
    return mk(n, 1, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, e, c);
  endfunction

  task automatic check(string n, int got, int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, got, want);
    end
  endtask

  initial begin
    // Reset and idle
    vecs.push_back(mk("rst_hold0", 0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, E_RST, ALL));
    vecs.push_back(mk("rst_hold1", 0, 0, 0, 0, 1, 1, 5'd5, 1, 5'd5, 0, 5'd0, E_RST, ALL));
    vecs.push_back(idle("idle_after_rst", E_IDLE, ALL));
    // Load-use via rs, then bubble clears the load
    vecs.push_back(mk("luh_rs", 1, 0, 0, 0, 1, 1, 5'd5, 1, 5'd5, 0, 5'd0, E_LUH, ALL));
    vecs.push_back(mk("luh_cleared", 1, 0, 0, 0, 0, 0, 5'd0, 1, 5'd5, 0, 5'd0, E_IDLE, ALL));
    vecs.push_back(mk("rd0_no_haz", 1, 0, 0, 0, 1, 1, 5'd0, 1, 5'd0, 1, 5'd0, E_IDLE, ALL));
    vecs.push_back(mk("luh_rt", 1, 0, 0, 0, 1, 1, 5'd7, 0, 5'd7, 1, 5'd7, E_LUH, ALL));
    vecs.push_back(mk("rt_unused", 1, 0, 0, 0, 1, 1, 5'd7, 0, 5'd3, 0, 5'd7, E_IDLE, ALL));
    vecs.push_back(mk("no_wr", 1, 0, 0, 0, 1, 0, 5'd5, 1, 5'd5, 0, 5'd0, E_IDLE, ALL));
    vecs.push_back(mk("not_load", 1, 0, 0, 0, 0, 1, 5'd5, 1, 5'd5, 0, 5'd0, E_IDLE, ALL));
    // Multiply, start while luh present (start wins), restart ignored when busy
    vecs.push_back(mk("mul_start", 1, 0, 1, 0, 1, 1, 5'd5, 1, 5'd5, 0, 5'd0, E_MCB, ALL));
    vecs.push_back(mk("mul_busy1", 1, 0, 1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, E_MCB, ALL));
    vecs.push_back(idle("mul_busy2", E_MCB, ALL));
    vecs.push_back(idle("mul_done", E_DONE, ALL));
    vecs.push_back(idle("mul_after", E_IDLE, ALL));
    // Multiply whose completion cycle sees a load-use hazard
    vecs.push_back(mk("mul2_start", 1, 0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, E_MCB, ALL));
    vecs.push_back(idle("mul2_busy1", E_MCB, ALL));
    vecs.push_back(idle("mul2_busy2", E_MCB, ALL));
    vecs.push_back(mk("mul2_done_luh", 1, 0, 0, 0, 1, 1, 5'd9, 1, 5'd9, 0, 5'd0, E_DONE | E_LUH, ALL));
    vecs.push_back(idle("mul2_after", E_IDLE, ALL));
    // Divide with a two-cycle freeze in the middle: done on cycle 14
    vecs.push_back(mk("div_start", 1, 0, 1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, E_MCB, ALL));
    for (int i = 0; i < 4; i++) vecs.push_back(idle("div_busy_a", E_MCB, ALL));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk("div_freeze", 1, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, E_FRZ, NOBUSY));
    for (int i = 0; i < 6; i++) vecs.push_back(idle("div_busy_b", E_MCB, ALL));
    vecs.push_back(idle("div_done", E_DONE, ALL));
    vecs.push_back(idle("div_after", E_IDLE, ALL));
    // mem_wait over load-use in IDLE, then the single luh bubble
    vecs.push_back(mk("frz_luh", 1, 1, 0, 0, 1, 1, 5'd5, 1, 5'd5, 0, 5'd0, E_FRZ, ALL));
    vecs.push_back(mk("luh_after_frz", 1, 0, 0, 0, 1, 1, 5'd5, 1, 5'd5, 0, 5'd0, E_LUH, ALL));
    vecs.push_back(mk("luh_after_bub", 1, 0, 0, 0, 0, 0, 5'd0, 1, 5'd5, 0, 5'd0, E_IDLE, ALL));
    // Start masked by mem_wait, re-presented, then reset aborts the op
    vecs.push_back(mk("frz_start", 1, 1, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, E_FRZ, ALL));
    vecs.push_back(mk("start_again", 1, 0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, E_MCB, ALL));
    vecs.push_back(idle("busy_pre_rst", E_MCB, ALL));
    vecs.push_back(mk("rst_mid_op", 0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, E_RST, ALL));
    vecs.push_back(mk("rst_mid_op2", 0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, E_RST, ALL));
    vecs.push_back(idle("no_done_after_rst", E_IDLE, ALL));
    vecs.push_back(idle("idle_after_rst2", E_IDLE, ALL));
    // Saturation: 20 frozen cycles
    for (int i = 0; i < 20; i++)
      vecs.push_back(mk("sat_freeze", 1, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, E_FRZ, ALL));
    vecs.push_back(idle("sat_final", E_IDLE, ALL));

    for (int i = 0; i < vecs.size(); i++) begin
      sb_t s;
      sb_t g;
      bit [6:0] got;
      @(posedge clock);
      #1;
      reset = vecs[i].rst; mem_wait = vecs[i].mw; ex_mc_start = vecs[i].st;
      ex_mc_div = vecs[i].dv; ex_is_load = vecs[i].ld; ex_writereg = vecs[i].wr;
      ex_regdest = vecs[i].rd; id_uses_rs = vecs[i].urs; id_rs = vecs[i].rs;
      id_uses_rt = vecs[i].urt; id_rt = vecs[i].rt;
      if (!vecs[i].rst) begin
        sc16 = 0;
        sc4  = 0;
      end
      s.name = vecs[i].name; s.exp = vecs[i].exp; s.care = vecs[i].care;
      s.sc16 = sc16; s.sc4 = sc4;
      sb_q.push_back(s);
      if (vecs[i].rst && vecs[i].exp[6]) begin
        sc16 = sc16 + 1;
        sc4  = (sc4 == 15) ? 15 : sc4 + 1;
      end

      @(negedge clock);
      g = sb_q.pop_front();
      got = {hold_if, hold_id, bubble_idex, hold_ex, bubble_exmem, mc_busy, mc_done};
      check({g.name, "_ctl"}, int'(got & g.care), int'(g.exp & g.care));
      check({g.name, "_cnt"}, int'(stall_count), g.sc16);
      check({g.name, "_cnt4"}, int'(s_stall_count), g.sc4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central pipeline stall/bubble controller for the 5-stage core.
- Detects load-use hazards at decode and sequences multi-cycle multiply/divide occupancy of the execute stage.
- Propagates data-memory wait freezes.
- Drives hold/bubble controls for the IF, ID, ID/EX and EX/MEM pipeline registers. The EX/MEM bubble feeds the execute-side register's `in_stall`.

Parameters:
- MULT_LAT, 4, total cycles a multiply occupies EX including the start cycle (must be >= 2)
- DIV_LAT, 12, total cycles a divide occupies EX including the start cycle (must be >= 2)
- CNT_W, 16, width of the stall performance counter

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_rs  in  5  decode-stage source register rs
- id_rt  in  5  decode-stage source register rt
- id_uses_rs  in  1  decode instruction reads rs
- id_uses_rt  in  1  decode instruction reads rt
- ex_regdest  in  5  destination register of the instruction in EX
- ex_writereg  in  1  EX instruction writes a register
- ex_is_load  in  1  EX instruction is a load
- ex_mc_start  in  1  EX instruction is a multi-cycle op (first EX cycle)
- ex_mc_div  in  1  qualifies ex_mc_start: 1 = divide, 0 = multiply
- mem_wait  in  1  data memory not ready; MEM stage must freeze
- hold_if  out  1  hold PC / fetch register
- hold_id  out  1  hold IF/ID register
- bubble_idex  out  1  load zeros/no-write into ID/EX
- hold_ex  out  1  hold ID/EX register (multi-cycle op stays in EX)
- bubble_exmem  out  1  stall into EX/MEM register (regdest=0, writereg=0, wbvalue=0)
- mc_busy  out  1  multi-cycle op in progress
- mc_done  out  1  one-cycle pulse: multi-cycle result advances this cycle
- stall_count  out  CNT_W  cycles with hold_if=1, saturating

Behaviour:
- States: IDLE, MC_BUSY. Registered: state, cnt (4 bits, covering DIV_LAT-2), stall_count. All control outputs are combinational from state, cnt and inputs.
- Reset (reset=0, async):
  - state=IDLE, cnt=0, stall_count=0.
  - While reset is low: hold_*=0, bubble_idex=1, bubble_exmem=1, mc_busy=0, mc_done=0.
  - Reset mid multi-cycle op aborts it; no mc_done.
- Load-use hazard (luh) = ex_is_load & ex_writereg & (ex_regdest!=0) & ((id_uses_rs & id_rs==ex_regdest) | (id_uses_rt & id_rt==ex_regdest)).
- Priority: mem_wait > multi-cycle (start or busy) > luh.
- mem_wait=1, any state:
  - hold_if=hold_id=hold_ex=1, both bubbles 0, mc_done=0.
  - state and cnt frozen; ex_mc_start ignored (it is re-presented when the freeze lifts).
- IDLE, ex_mc_start=1:
  - cnt<=(ex_mc_div ? DIV_LAT : MULT_LAT)-2, state<=MC_BUSY.
  - This cycle: hold_if=hold_id=hold_ex=1, bubble_exmem=1, bubble_idex=0, mc_busy=1.
- MC_BUSY, cnt!=0: same outputs as the start cycle; cnt<=cnt-1.
- MC_BUSY, cnt==0 (completion cycle):
  - mc_done=1, mc_busy=0, hold_ex=0, bubble_exmem=0, state<=IDLE.
  - hold_if/hold_id/bubble_idex follow the IDLE luh rule.
- IDLE, no start, luh=1: hold_if=hold_id=1, bubble_idex=1, hold_ex=0, bubble_exmem=0. Lasts exactly one cycle, because the bubble clears ex_is_load.
- IDLE, nothing pending: all outputs 0.
- ex_mc_start while in MC_BUSY is ignored (a second op cannot be in EX).
- ex_regdest=0 never creates a hazard.
- stall_count increments on every clock where hold_if=1 and reset=1; it holds at 2^CNT_W-1.
- Result: a multi-cycle op occupies EX for exactly LAT cycles and inserts LAT-1 bubbles into EX/MEM.

Test Plan:
- Reset release, idle inputs -> all outputs 0, stall_count=0; assert reset mid-MC_BUSY -> state IDLE, bubbles=1 while low, no mc_done.
- Load r5 in EX (ex_is_load=1, ex_regdest=5, ex_writereg=1), decode id_rs=5, id_uses_rs=1 -> exactly one cycle of hold_if=hold_id=bubble_idex=1; stall_count=1. Repeat with ex_regdest=0 -> no stall.
- ex_mc_start=1, ex_mc_div=0, MULT_LAT=4 -> hold_ex/bubble_exmem=1 for 3 cycles, mc_done=1 on the 4th, stall_count=3.
- Divide (DIV_LAT=12) with mem_wait=1 for 2 cycles mid-op -> mc_done on cycle 14, hold_ex=1 throughout the freeze, bubble_exmem=0 during the freeze.
- mem_wait=1 coincident with luh=1 in IDLE -> holds=1, bubble_idex=0; after mem_wait drops, one luh bubble cycle.
- CNT_W=4, 20 held cycles -> stall_count saturates at 15.
